// File: rtl/hole_pocket_detector.sv
`default_nettype none
// ============================================================================
// Module      : hole_pocket_detector
// Description : Counts ball/hole pixel overlap over each video frame. At every
//               frame boundary it decides which balls fell into a pocket.
//               Pocketed balls produce a one-cycle pulse and bump a saturating
//               counter. A per-ball cooldown stops one pocketing from being
//               reported more than once.
// Ports       : clk                 - pixel clock
//               resetN              - asynchronous active-low reset
//               startOfFrame        - one-cycle frame start pulse
//               holesDrawingRequest - merged drawing request of all holes
//               ballsDrawingRequest - per-ball drawing request
//               ballsEnable         - per-ball "still on table"
//               pocketPulse         - per-ball one-cycle pocket pulse
//               pocketedCount       - total pockets since reset, saturating at 15
//               armed               - high once the first full frame has begun
//               lastOverlap0        - final ball-0 overlap of the last evaluated
//                                     frame (only with POCKET_DEBUG_EN defined)
// Options     : define POCKET_DEBUG_EN to add the lastOverlap0 debug output.
// Revision    : 1.0 - initial release
// ============================================================================
module hole_pocket_detector #(
  parameter int NUM_BALLS       = 4,
  parameter int OVERLAP_THRESH  = 16,
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 holesDrawingRequest,
  input  logic [NUM_BALLS-1:0] ballsDrawingRequest,
  input  logic [NUM_BALLS-1:0] ballsEnable,
  output logic [NUM_BALLS-1:0] pocketPulse,
  output logic [3:0]           pocketedCount,
  output logic                 armed
`ifdef POCKET_DEBUG_EN
  ,
  output logic [7:0]           lastOverlap0
`endif
);

  localparam logic [7:0] THRESH    = 8'(OVERLAP_THRESH);
  localparam logic [7:0] COOL_LOAD = 8'(COOLDOWN_FRAMES);

  typedef enum logic [0:0] {
    WAIT_FRAME = 1'b0,
    RUN        = 1'b1
  } state_t;

  state_t state;

  logic [7:0] ovl  [NUM_BALLS];
  logic [7:0] cool [NUM_BALLS];

  logic [NUM_BALLS-1:0] hit;      // ball counts an overlap pixel this cycle
  logic [NUM_BALLS-1:0] pocket;   // ball is judged pocketed this cycle
  logic [7:0]           pop;
  logic [8:0]           cnt_sum;
  logic [3:0]           next_count;
  logic                 eval;

  // Evaluation only happens on a frame start once the block is running; the
  // arming frame start in WAIT_FRAME never evaluates.
  assign eval = (state == RUN) && startOfFrame;

  always_comb begin
    hit    = '0;
    pocket = '0;
    pop    = '0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      hit[i]    = holesDrawingRequest && ballsDrawingRequest[i] &&
                  ballsEnable[i] && (cool[i] == 8'd0);
      pocket[i] = eval && ballsEnable[i] && (cool[i] == 8'd0) &&
                  (ovl[i] >= THRESH);
      pop       = pop + {7'd0, pocket[i]};
    end
    cnt_sum    = {5'd0, pocketedCount} + {1'b0, pop};
    next_count = (cnt_sum > 9'd15) ? 4'd15 : cnt_sum[3:0];
  end

  // Top FSM: waits for the first frame start so a partial frame after reset
  // is never evaluated.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= WAIT_FRAME;
      armed <= 1'b0;
    end else begin
      case (state)
        WAIT_FRAME: begin
          if (startOfFrame) begin
            state <= RUN;
            armed <= 1'b1;
          end
        end
        RUN:     state <= RUN;
        default: state <= WAIT_FRAME;
      endcase
    end
  end

  // Per-ball overlap counters and cooldown timers (cool==0 is ARMED,
  // cool!=0 is COOLDOWN).
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pocketPulse   <= '0;
      pocketedCount <= 4'd0;
      for (int i = 0; i < NUM_BALLS; i++) begin
        ovl[i]  <= 8'd0;
        cool[i] <= 8'd0;
      end
    end else begin
      // pocket is zero except on an evaluating frame start, so the pulse
      // lasts exactly one cycle and the count only moves then.
      pocketPulse   <= pocket;
      pocketedCount <= next_count;
      if (state == RUN) begin
        for (int i = 0; i < NUM_BALLS; i++) begin
          if (startOfFrame) begin
            // An overlap on the frame-start cycle belongs to the new frame.
            ovl[i] <= hit[i] ? 8'd1 : 8'd0;
            if (pocket[i]) begin
              cool[i] <= COOL_LOAD;
            end else if (cool[i] != 8'd0) begin
              cool[i] <= cool[i] - 8'd1;
            end
          end else if (hit[i] && (ovl[i] != 8'hFF)) begin
            ovl[i] <= ovl[i] + 8'd1;
          end
        end
      end
    end
  end

`ifdef POCKET_DEBUG_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lastOverlap0 <= 8'd0;
    end else if (eval) begin
      lastOverlap0 <= ovl[0];
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hole_pocket_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_hole_pocket_detector
// Description : Directed self-checking bench for hole_pocket_detector with
//               hand-computed expected pulses and counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hole_pocket_detector;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic       holesDrawingRequest;
  logic [3:0] ballsDrawingRequest;
  logic [3:0] ballsEnable;
  logic [3:0] pocketPulse;
  logic [3:0] pocketedCount;
  logic       armed;
`ifdef POCKET_DEBUG_EN
  logic [7:0] lastOverlap0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hole_pocket_detector #(
    .NUM_BALLS      (4),
    .OVERLAP_THRESH (16),
    .COOLDOWN_FRAMES(30)
  ) dut (
    .clk                (clk),
    .resetN             (resetN),
    .startOfFrame       (startOfFrame),
    .holesDrawingRequest(holesDrawingRequest),
    .ballsDrawingRequest(ballsDrawingRequest),
    .ballsEnable        (ballsEnable),
    .pocketPulse        (pocketPulse),
    .pocketedCount      (pocketedCount),
    .armed              (armed)
`ifdef POCKET_DEBUG_EN
    ,
    .lastOverlap0       (lastOverlap0)
`endif
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs set before this are sampled at the edge and
  // outputs are read 1 ns after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic overlap(input logic [3:0] mask, input int n);
    holesDrawingRequest = 1'b1;
    ballsDrawingRequest = mask;
    repeat (n) cycle();
    holesDrawingRequest = 1'b0;
    ballsDrawingRequest = 4'b0000;
    cycle();
  endtask

  // Frame boundary with optional overlap on the frame-start cycle itself.
  task automatic frame_end(input string tag, input logic [3:0] exp_pulse,
                           input int exp_cnt, input logic [3:0] sof_mask);
    check_val({tag, "_pre"}, int'(pocketPulse), 0);
    startOfFrame        = 1'b1;
    holesDrawingRequest = |sof_mask;
    ballsDrawingRequest = sof_mask;
    cycle();
    startOfFrame        = 1'b0;
    holesDrawingRequest = 1'b0;
    ballsDrawingRequest = 4'b0000;
    check_val({tag, "_pulse"}, int'(pocketPulse), int'(exp_pulse));
    check_val({tag, "_cnt"}, int'(pocketedCount), exp_cnt);
    cycle();
    check_val({tag, "_post"}, int'(pocketPulse), 0);
  endtask

  task automatic idle_frames(input int n);
    repeat (n) begin
      startOfFrame = 1'b1;
      cycle();
      startOfFrame = 1'b0;
      cycle();
    end
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    #3;
    check_val("rst_pulse", int'(pocketPulse), 0);
    check_val("rst_cnt", int'(pocketedCount), 0);
    check_val("rst_armed", int'(armed), 0);
    cycle();
    resetN = 1'b1;
    cycle();
  endtask

  initial begin
    resetN              = 1'b1;
    startOfFrame        = 1'b0;
    holesDrawingRequest = 1'b0;
    ballsDrawingRequest = 4'b0000;
    ballsEnable         = 4'b1111;
    cycle();
    do_reset();

    // Partial frame after reset is ignored; first frame start only arms.
    overlap(4'b0001, 20);
    check_val("armed_before", int'(armed), 0);
    frame_end("arm", 4'b0000, 0, 4'b0000);
    check_val("armed_after", int'(armed), 1);
`ifdef POCKET_DEBUG_EN
    check_val("dbg_arm", int'(lastOverlap0), 0);
`endif
    frame_end("empty", 4'b0000, 0, 4'b0000);

    // Ball 1 pocketed with 20 overlaps.
    overlap(4'b0010, 20);
    frame_end("b1", 4'b0010, 1, 4'b0000);

    // Threshold boundary on ball 0: 15 no, 16 yes.
    overlap(4'b0001, 15);
    frame_end("b0_15", 4'b0000, 1, 4'b0000);
`ifdef POCKET_DEBUG_EN
    check_val("dbg_15", int'(lastOverlap0), 15);
`endif
    overlap(4'b0001, 16);
    frame_end("b0_16", 4'b0001, 2, 4'b0000);

    // Ball 2 cooldown: 30 frames ignored, then re-armed.
    overlap(4'b0100, 20);
    frame_end("b2", 4'b0100, 3, 4'b0000);
    for (int f = 0; f < 30; f++) begin
      overlap(4'b0100, 20);
      frame_end("b2_cool", 4'b0000, 3, 4'b0000);
    end
    overlap(4'b0100, 20);
    frame_end("b2_rearm", 4'b0100, 4, 4'b0000);

    // Balls 0 and 3 together.
    overlap(4'b1001, 16);
    frame_end("b03", 4'b1001, 6, 4'b0000);

    // Ball 1 disabled for the whole frame never pulses.
    ballsEnable = 4'b1101;
    overlap(4'b0010, 40);
    frame_end("b1_dis", 4'b0000, 6, 4'b0000);
    ballsEnable = 4'b1111;

    // Disabling mid-frame freezes the count at 10 (below threshold).
    overlap(4'b0010, 10);
    ballsEnable = 4'b1101;
    overlap(4'b0010, 10);
    ballsEnable = 4'b1111;
    frame_end("b1_freeze", 4'b0000, 6, 4'b0000);

    // Frozen value at threshold is still evaluated.
    overlap(4'b0010, 16);
    ballsEnable = 4'b1101;
    overlap(4'b0010, 5);
    ballsEnable = 4'b1111;
    frame_end("b1_frozen16", 4'b0010, 7, 4'b0000);

    // Reset mid-frame: nothing reported for the interrupted frame.
    overlap(4'b1111, 20);
    do_reset();
    frame_end("rst2_arm", 4'b0000, 0, 4'b0000);
    check_val("rst2_armed", int'(armed), 1);

    // Overlap on the frame-start cycle belongs to the new frame.
    overlap(4'b0001, 15);
    frame_end("sof_old", 4'b0000, 0, 4'b0001);
`ifdef POCKET_DEBUG_EN
    check_val("dbg_sof_old", int'(lastOverlap0), 15);
`endif
    overlap(4'b0001, 15);
    frame_end("sof_new", 4'b0001, 1, 4'b0000);
`ifdef POCKET_DEBUG_EN
    check_val("dbg_sof_new", int'(lastOverlap0), 16);
`endif

    // Saturation: 1 -> 5 -> 9 -> 13 -> 14 -> 15 (14 + 3 clamps).
    idle_frames(30);
    overlap(4'b1111, 16);
    frame_end("sat_a", 4'b1111, 5, 4'b0000);
    idle_frames(30);
    overlap(4'b1111, 16);
    frame_end("sat_b", 4'b1111, 9, 4'b0000);
    idle_frames(30);
    overlap(4'b1111, 16);
    frame_end("sat_c", 4'b1111, 13, 4'b0000);
    idle_frames(30);
    overlap(4'b0001, 16);
    frame_end("sat_14", 4'b0001, 14, 4'b0000);
    overlap(4'b1110, 16);
    frame_end("sat_15", 4'b1110, 15, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hole_pocket_detector.md
Name: hole_pocket_detector

Overview:
- Sits directly downstream of the six-hole merge stage.
- Consumes the merged holes drawing request together with the per-ball drawing requests.
- Counts ball/hole pixel overlap across each video frame and, at the frame boundary, decides which balls fell into a pocket.
- Emits one-cycle pocket pulses to game logic and a running pocketed-ball counter, with a per-ball cooldown so a single pocketing is reported once.

Parameters:
- NUM_BALLS, 4, number of ball objects tracked; sets the width of the ball vectors.
- OVERLAP_THRESH, 16, minimum overlapping pixels in one frame to declare a pocket (range 1..255).
- COOLDOWN_FRAMES, 30, frames a ball is ignored after being pocketed (range 1..255).

Ports:
- clk  in  1  pixel clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse at the start of each frame, from the VGA controller.
- holesDrawingRequest  in  1  merged drawing request of all holes.
- ballsDrawingRequest  in  NUM_BALLS  per-ball drawing request; bit i is ball i.
- ballsEnable  in  NUM_BALLS  ball i still on the table; a disabled ball never counts or pulses.
- pocketPulse  out  NUM_BALLS  bit i high for exactly one cycle when ball i is pocketed.
- pocketedCount  out  4  total pockets since reset; saturates at 15.
- armed  out  1  high once the first full frame has begun.

Behaviour:
- Reset: asynchronous, active-low.
  - All outputs go to 0.
  - Overlap counters clear, cooldown counters clear, top FSM enters WAIT_FRAME.
- Top FSM:
  - WAIT_FRAME: ignores all pixel inputs. The first startOfFrame moves it to RUN and sets armed=1.
  - RUN: stays in RUN until reset.
  - Purpose: a partial frame following reset is never evaluated.
- Overlap counting, RUN only:
  - ovl[i] is 8 bits and saturates at 255.
  - It increments on every cycle where holesDrawingRequest && ballsDrawingRequest[i] && ballsEnable[i] && cool[i]==0.
- Frame evaluation, on each startOfFrame cycle in RUN:
  - If ovl[i] >= OVERLAP_THRESH and cool[i]==0: register pocketPulse[i]=1, visible the cycle after startOfFrame, and load cool[i]=COOLDOWN_FRAMES.
  - Else if cool[i]!=0: cool[i] decrements by 1.
  - In every case ovl[i] restarts for the new frame.
- Latency: pocketPulse rises exactly 1 clk after startOfFrame and is low on all other cycles.
- Simultaneous events:
  - Overlap on the startOfFrame cycle belongs to the new frame: ovl[i] is set to 1, not 0. It does not count toward the frame being evaluated.
  - Several balls pocketed in the same frame: all their pulse bits are set in the same cycle, and pocketedCount adds the popcount of those bits in one step, saturating at 15.
  - The first startOfFrame after reset, taken in WAIT_FRAME, only arms the block and never evaluates.
- Enable edge cases:
  - ballsEnable[i] dropping mid-frame freezes ovl[i]; the frozen value is still evaluated at the next startOfFrame.
  - A ball whose ballsEnable[i] is low at startOfFrame never pulses.
- Reset mid-frame: counters are lost and the FSM returns to WAIT_FRAME. No pulse is emitted for the interrupted frame.
- Per-ball FSM: ARMED (cool==0) and COOLDOWN (cool!=0).
  - ARMED -> COOLDOWN on pocket.
  - COOLDOWN -> ARMED when cool decrements to 0.

Optional Feature:
- Macro: POCKET_DEBUG_EN.
- Defined: adds output port lastOverlap0 [7:0].
  - At each evaluating startOfFrame it latches the frame's final ovl[0] value.
  - It holds that value until the next evaluation.
  - Reset value is 0.
- Undefined: the port and its register are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then overlap on ball 0 in the partial frame, then the first startOfFrame -> armed=1, no pocketPulse, pocketedCount=0.
- Armed; 20 overlap cycles on ball 1 within one frame (THRESH=16), then startOfFrame -> pocketPulse=4'b0010 for exactly one cycle, 1 clk after startOfFrame; pocketedCount=1.
- Armed; 15 overlap cycles on ball 0, then startOfFrame -> no pulse. Next frame with 16 overlap cycles -> pulse 4'b0001.
- Ball 2 pocketed, then 20 overlap cycles in each of the next 30 frames -> no further pulse. On frame 31 the ball is re-armed, and 20 overlaps then give a pulse.
- Balls 0 and 3 each with 16 overlaps in one frame -> pocketPulse=4'b1001 in the same cycle and pocketedCount +2. Repeated pockets from count 14 -> saturates at 15.
- ballsEnable[1]=0 with 40 overlap cycles on ball 1 -> no pulse. Overlap asserted on the startOfFrame cycle -> counts 1 toward the new frame (checked via lastOverlap0 with POCKET_DEBUG_EN defined).
